// File: rtl/fixed_point_abs_pipe.sv
// rtl/fixed_point_abs_pipe.sv - two-stage multi-lane fixed-point |x| with sign, MIN flag and saturation counter
module fixed_point_abs_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4,
   parameter bit SAT_EN     = 1'b1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] out_abs,
   output logic [LANES-1:0]            out_sign,
   output logic [LANES-1:0]            out_sat,
   output logic [CNT_WIDTH-1:0]        sat_count,
   input  logic                        sat_count_clr
);

   localparam int W  = LANES * DATA_WIDTH;
   localparam int PW = $clog2(LANES + 1);
   localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
   localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

   logic             s1_valid;
   logic [W-1:0]     s1_data;
   logic [LANES-1:0] s1_sign;
   logic             s2_valid;
   logic [W-1:0]     s2_abs;
   logic [LANES-1:0] s2_sign;
   logic [LANES-1:0] s2_sat;

   logic             s1_ready;
   logic             s2_ready;
   logic             in_fire;
   logic             s1_move;
   logic             out_fire;
   logic [LANES-1:0] in_sign;
   logic [W-1:0]     abs_next;
   logic [LANES-1:0] sat_next;
   logic [DATA_WIDTH-1:0] lane;
   logic [PW-1:0]    sat_pop;
   logic [SW-1:0]    cnt_sum;

   // Ready chain looks only at downstream state, never at in_valid.
   assign s2_ready = !s2_valid || out_ready;
   assign s1_ready = !s1_valid || s2_ready;
   assign in_ready = s1_ready;
   assign in_fire  = in_valid && s1_ready;
   assign s1_move  = s1_valid && s2_ready;
   assign out_fire = s2_valid && out_ready;

   always_comb begin
      in_sign = '0;
      for (int i = 0; i < LANES; i++) begin
         in_sign[i] = in_data[i*DATA_WIDTH + DATA_WIDTH - 1];
      end
   end

   always_comb begin
      abs_next = '0;
      sat_next = '0;
      lane     = '0;
      for (int i = 0; i < LANES; i++) begin
         lane = s1_data[i*DATA_WIDTH +: DATA_WIDTH];
         if (!s1_sign[i]) begin
            abs_next[i*DATA_WIDTH +: DATA_WIDTH] = lane;
         end else if (lane == MIN_VAL) begin
            sat_next[i] = 1'b1;
            abs_next[i*DATA_WIDTH +: DATA_WIDTH] = SAT_EN ? MAX_VAL : lane;
         end else begin
            abs_next[i*DATA_WIDTH +: DATA_WIDTH] = ~lane + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_sign  <= '0;
      end else begin
         if (s1_ready) s1_valid <= in_valid;
         if (in_fire) begin
            s1_data <= in_data;
            s1_sign <= in_sign;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_abs   <= '0;
         s2_sign  <= '0;
         s2_sat   <= '0;
      end else begin
         if (s2_ready) s2_valid <= s1_valid;
         if (s1_move) begin
            s2_abs  <= abs_next;
            s2_sign <= s1_sign;
            s2_sat  <= sat_next;
         end
      end
   end

   always_comb begin
      sat_pop = '0;
      for (int i = 0; i < LANES; i++) begin
         sat_pop = sat_pop + PW'(s2_sat[i]);
      end
   end

   assign cnt_sum = SW'(sat_count) + SW'(sat_pop);

   // Clear takes priority and discards the increment of the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
      end else if (sat_count_clr) begin
         sat_count <= '0;
      end else if (out_fire) begin
         sat_count <= (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_WIDTH-1:0];
      end
   end

   assign out_valid = s2_valid;
   assign out_abs   = s2_abs;
   assign out_sign  = s2_sign;
   assign out_sat   = s2_sat;

endmodule

// File: tb/tb_fixed_point_abs_pipe.sv
// tb/tb_fixed_point_abs_pipe.sv - bench for fixed_point_abs_pipe (saturating and wrapping instances)
module tb_fixed_point_abs_pipe;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic sat_count_clr = 1'b0;
   logic [W-1:0] in_data = '0;

   logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
   logic [W-1:0] out_abs_a, out_abs_b;
   logic [3:0]   out_sign_a, out_sat_a, out_sign_b, out_sat_b;
   logic [2:0]   sat_count_a;
   logic [15:0]  sat_count_b;

   fixed_point_abs_pipe #(.DATA_WIDTH(8), .LANES(4), .SAT_EN(1'b1), .CNT_WIDTH(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_abs(out_abs_a), .out_sign(out_sign_a),
      .out_sat(out_sat_a), .sat_count(sat_count_a), .sat_count_clr(sat_count_clr));

   fixed_point_abs_pipe #(.DATA_WIDTH(8), .LANES(4), .SAT_EN(1'b0), .CNT_WIDTH(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_abs(out_abs_b), .out_sign(out_sign_b),
      .out_sat(out_sat_b), .sat_count(sat_count_b), .sat_count_clr(sat_count_clr));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] abs_s;
      logic [31:0] abs_w;
      logic [3:0]  sign;
      logic [3:0]  sat;
   } exp_t;

   typedef struct {
      logic [31:0] din;
      logic [31:0] abs_s;
      logic [31:0] abs_w;
      logic [3:0]  sign;
      logic [3:0]  sat;
      int          cnt;
   } vec_t;

   exp_t exp_q[$];
   int checks = 0;
   int failures = 0;
   int fires = 0;
   int m_cnt_a = 0;
   int m_cnt_b = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Reference: signed integer magnitude per lane; MIN either clamps or keeps its bit pattern.
   function automatic exp_t model(input logic [31:0] d);
      exp_t e;
      byte  b;
      int   v, a;
      e = '{32'h0, 32'h0, 4'h0, 4'h0};
      for (int l = 0; l < 4; l++) begin
         b = d[l*8 +: 8];
         v = b;
         a = (v < 0) ? -v : v;
         e.sign[l] = (v < 0);
         e.sat[l]  = (v == -128);
         e.abs_w[l*8 +: 8] = a[7:0];
         e.abs_s[l*8 +: 8] = (v == -128) ? 8'd127 : a[7:0];
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_beat();
      logic [31:0] d;
      for (int l = 0; l < 4; l++) begin
         d[l*8 +: 8] = ($urandom_range(3) == 0) ? 8'h80 : 8'($urandom);
      end
      return d;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      int pop;
      if (!rst_n) begin
         exp_q.delete();
         m_cnt_a = 0;
         m_cnt_b = 0;
      end else begin
         check("mon_cnt_a", sat_count_a, m_cnt_a);
         check("mon_cnt_b", sat_count_b, m_cnt_b);
         check("mon_valid_b", out_valid_b, out_valid_a);
         pop = 0;
         if (out_valid_a && out_ready) begin
            if (exp_q.size() == 0) begin
               check("mon_queue_depth", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("mon_abs_a", out_abs_a, e.abs_s);
               check("mon_abs_b", out_abs_b, e.abs_w);
               check("mon_sign", {out_sign_b, out_sign_a}, {e.sign, e.sign});
               check("mon_sat", {out_sat_b, out_sat_a}, {e.sat, e.sat});
               pop = $countones(e.sat);
               fires++;
            end
         end
         if (sat_count_clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
         end else begin
            m_cnt_a = (m_cnt_a + pop > 7) ? 7 : m_cnt_a + pop;
            m_cnt_b = (m_cnt_b + pop > 65535) ? 65535 : m_cnt_b + pop;
         end
         if (in_valid && in_ready_a) exp_q.push_back(model(in_data));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[5];
      logic [31:0] bp[5];
      logic [31:0] held_abs;
      logic [3:0]  held_sign, held_sat;
      logic [31:0] z;
      exp_t        ez;
      int          k, fires0;
      bit          acc;
      int          lim_a[3];
      int          lim_b[3];

      tbl[0] = '{32'h8000FB05, 32'h7F000505, 32'h80000505, 4'b1010, 4'b1000, 1};
      tbl[1] = '{32'h7F81FF01, 32'h7F7F0101, 32'h7F7F0101, 4'b0110, 4'b0000, 1};
      tbl[2] = '{32'h80808080, 32'h7F7F7F7F, 32'h80808080, 4'b1111, 4'b1111, 5};
      tbl[3] = '{32'h00000000, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000, 5};
      tbl[4] = '{32'h017EC040, 32'h017E4040, 32'h017E4040, 4'b0010, 4'b0000, 5};
      lim_a = '{4, 7, 7};
      lim_b = '{4, 8, 12};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid_a, 0);
      check("rst_out_abs", {out_abs_a, out_abs_b}, 64'h0);
      check("rst_sign_sat", {out_sign_a, out_sat_a, out_sign_b, out_sat_b}, 16'h0);
      check("rst_sat_count", {sat_count_a, sat_count_b}, 19'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready_a, 1);
      step();

      // table vectors: accepted at edge N, visible after edge N+1, counted after edge N+2
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = tbl[i].din;
         @(negedge clk);
         check($sformatf("tbl%0d_in_ready", i), in_ready_a, 1);
         step();
         in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("tbl%0d_early_valid", i), out_valid_a, 0);
         step();
         @(negedge clk);
         check($sformatf("tbl%0d_valid", i), out_valid_a, 1);
         check($sformatf("tbl%0d_abs_sat", i), out_abs_a, tbl[i].abs_s);
         check($sformatf("tbl%0d_abs_wrap", i), out_abs_b, tbl[i].abs_w);
         check($sformatf("tbl%0d_sign", i), out_sign_a, tbl[i].sign);
         check($sformatf("tbl%0d_sat", i), out_sat_b, tbl[i].sat);
         step();
         @(negedge clk);
         check($sformatf("tbl%0d_cnt", i), {sat_count_b, 13'h0, sat_count_a}, {16'(tbl[i].cnt), 13'h0, 3'(tbl[i].cnt)});
         step();
      end

      // backpressure: two beats fill the pipe, output held while stalled
      for (int i = 0; i < 5; i++) bp[i] = rand_beat();
      out_ready = 1'b0;
      k = 0;
      fires0 = fires;
      held_abs = '0;
      held_sign = '0;
      held_sat = '0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         in_valid = 1'b1;
         in_data  = bp[k];
         @(negedge clk);
         acc = in_valid && in_ready_a;
         if (cyc >= 2) check($sformatf("bp_in_ready_c%0d", cyc), in_ready_a, 0);
         if (cyc == 2) begin
            check("bp_out_valid", out_valid_a, 1);
            held_abs = out_abs_a;
            held_sign = out_sign_a;
            held_sat = out_sat_a;
         end else if (cyc > 2) begin
            check($sformatf("bp_hold_c%0d", cyc), {out_abs_a, out_sign_a, out_sat_a}, {held_abs, held_sign, held_sat});
         end
         step();
         if (acc) k++;
      end
      check("bp_accepted", k, 2);
      out_ready = 1'b1;
      for (int n = 0; n < 30 && (k < 5 || fires - fires0 < 5); n++) begin
         in_valid = (k < 5);
         if (k < 5) in_data = bp[k];
         @(negedge clk);
         acc = in_valid && in_ready_a;
         step();
         if (acc) k++;
      end
      in_valid = 1'b0;
      step();
      check("bp_delivered", fires - fires0, 5);
      check("bp_queue_empty", exp_q.size(), 0);

      // throughput: 100 back-to-back beats, one output per cycle from the second edge on
      fires0 = fires;
      for (int i = 0; i < 102; i++) begin
         in_valid = (i < 100);
         in_data  = rand_beat();
         @(negedge clk);
         check($sformatf("thru_valid_%0d", i), out_valid_a, (i >= 2 && i <= 101));
         if (i < 100) check($sformatf("thru_in_ready_%0d", i), in_ready_a, 1);
         step();
      end
      in_valid = 1'b0;
      check("thru_count", fires - fires0, 100);

      // reset with both stages full
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = rand_beat();
      step();
      in_data = rand_beat();
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_full_valid", {out_valid_a, in_ready_a}, 2'b10);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_out_valid", {out_valid_a, out_valid_b}, 2'b00);
      check("mid_sat_count", {sat_count_a, sat_count_b}, 19'h0);
      check("mid_out_abs", out_abs_a, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rel_ready", {in_ready_a, out_valid_a}, 2'b10);
      step();
      z = rand_beat();
      ez = model(z);
      in_valid = 1'b1;
      in_data = z;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_new_early", out_valid_a, 0);
      step();
      @(negedge clk);
      check("mid_new_valid", out_valid_a, 1);
      check("mid_new_abs", {out_abs_a, out_abs_b}, {ez.abs_s, ez.abs_w});
      step();
      step();

      // counter limits with all-MIN beats
      sat_count_clr = 1'b1;
      step();
      sat_count_clr = 1'b0;
      @(negedge clk);
      check("lim_clear", {sat_count_a, sat_count_b}, 19'h0);
      step();
      for (int r = 0; r < 3; r++) begin
         in_valid = 1'b1;
         in_data = 32'h80808080;
         step();
         in_valid = 1'b0;
         step();
         step();
         @(negedge clk);
         check($sformatf("lim_cnt_a_%0d", r), sat_count_a, lim_a[r]);
         check($sformatf("lim_cnt_b_%0d", r), sat_count_b, lim_b[r]);
         step();
      end
      in_valid = 1'b1;
      in_data = 32'h80808080;
      step();
      in_valid = 1'b0;
      step();
      sat_count_clr = 1'b1;
      @(negedge clk);
      check("clr_fire_valid", out_valid_a, 1);
      step();
      sat_count_clr = 1'b0;
      @(negedge clk);
      check("clr_wins", {sat_count_a, sat_count_b}, 19'h0);
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
